aes_out_stream: RTL and testbench
=================================

# aes_out_stream

Drains the AES output FIFO after the AES controller signals completion and streams the processed blocks out as a 32-bit AXI4-Stream master. It sits between the output FIFO's read port and the DMA-facing stream interface. For each block it performs one FIFO read, then emits the block as four 32-bit beats, with `TLAST` on the final beat of the final block.

## Interface
Parameters:
- `OUT_FIFO_ADDR_WIDTH`, 9, output FIFO address width.
- `OUT_FIFO_DATA_WIDTH`, 128, FIFO word width; fixed at 128.
- `C_M_AXIS_TDATA_WIDTH`, 32, stream width; fixed at 32.

Ports:
- `clk` in 1 — single clock.
- `reset` in 1 — synchronous, active-high.
- `en` in 1 — start pulse, driven by the controller's `en_o`.
- `blk_cnt` in `OUT_FIFO_ADDR_WIDTH` — number of blocks to send; sampled on the `en` cycle.
- `out_fifo_r_e` out 1 — FIFO read enable; registered.
- `out_fifo_addr` out `OUT_FIFO_ADDR_WIDTH` — FIFO read address; registered.
- `out_fifo_data` in [0:127] — FIFO read data; valid one cycle after `out_fifo_r_e`.
- `m_axis_tdata` out 32 — stream data.
- `m_axis_tvalid` out 1 — stream valid.
- `m_axis_tready` in 1 — stream ready.
- `m_axis_tlast` out 1 — stream last.
- `busy` out 1 — high from the edge that accepts `en` until the `en_o` edge.
- `en_o` out 1 — one-cycle done pulse.

## Operation
- Reset values: all outputs 0; state IDLE; internal pointers 0.
- FSM states are IDLE, FETCH, LOAD, SEND, DONE.
- IDLE:
  - `en`=1 with `blk_cnt`≠0: latch `blk_cnt`, set `rd_ptr`=0, assert `out_fifo_r_e`=1 with `out_fifo_addr`=0, go to FETCH.
  - `en`=1 with `blk_cnt`=0: go to DONE; no FIFO read, no beats.
- FETCH: deassert `out_fifo_r_e`; go to LOAD.
- LOAD: capture `out_fifo_data` into the shift register; set `beat`=0 and `m_axis_tvalid`=1; go to SEND.
- SEND: beat *i* carries `tdata` = block[i*32 +: 32], where word 0 is bits [0:31] (MSB-first). No byte reordering.
  - Each handshake (`tvalid & tready`) advances `beat`.
  - On beat 3, if `rd_ptr+1` = `blk_cnt`: drop `tvalid`, go to DONE.
  - On beat 3 otherwise: increment `rd_ptr`, issue a read of the new `rd_ptr`, drop `tvalid`, go to FETCH.
- `m_axis_tlast` = 1 only while presenting beat 3 of block `blk_cnt-1`.
- DONE: `en_o`=1 for exactly one cycle; clear `busy`; return to IDLE.
- `en` is ignored while `busy`=1.
- `rd_ptr` range is 0..`blk_cnt-1`, so there is no address wrap. `blk_cnt`=2^W−1 is the largest supported count.
- AXIS rule: once `tvalid`=1, `tdata` and `tlast` hold until the handshake.
- Reset mid-transfer: the next edge forces IDLE and drops `tvalid` with no handshake. No `en_o` is generated.

## Timing
- `en` sampled at edge t:
  - `out_fifo_r_e`=1 during cycle t..t+1.
  - FIFO data is valid during t+1..t+2.
  - `tvalid` rises at edge t+2.
- With `tready` held at 1, a block takes 4 consecutive beat cycles.
- Without prefetch, each block boundary costs 2 idle `tvalid` cycles (FETCH, LOAD).
- With `blk_cnt`=N and `tready`=1, the final handshake is at edge t+2+6N−2. `en_o` is high during the cycle after the final handshake edge.
- `blk_cnt`=0: `en_o` is high during the cycle after edge t+1.

## Configuration
- `AES_OUT_PREFETCH_EN` defined:
  - Adds a 128-bit hold buffer.
  - On entering SEND for block k with k+1 < `blk_cnt`, the read for block k+1 is issued at the same edge; its data is captured into the hold buffer one cycle later.
  - On the beat-3 handshake, the hold buffer loads the shift register and `tvalid` stays 1.
  - Result: zero bubble cycles between blocks; N blocks take 4N beat cycles plus 2 cycles of startup.
- Undefined: no hold buffer; the 2-cycle inter-block bubble described under Timing applies.
- In both configurations, beat order, `tlast`, `en_o` and reset behaviour are identical.

## Test plan
- `blk_cnt`=1, FIFO[0]=0x00112233_44556677_8899AABB_CCDDEEFF, `tready`=1 → beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF; `tlast` only on the 4th; `en_o` pulses once.
- `blk_cnt`=3, incrementing data, `tready`=1 → 12 beats in order, FIFO addresses 0,1,2 read once each.
  - Without the macro: `tvalid` low for exactly 2 cycles after beats 4 and 8.
  - With the macro: `tvalid` continuous.
- `blk_cnt`=2, `tready` toggling 1,0,0,1,… → `tdata` and `tlast` stable while stalled; 8 beats delivered in order.
- `blk_cnt`=0 → no `out_fifo_r_e`, no `tvalid`; `en_o` high during the cycle after edge t+1.
- Second `en` during `busy` → ignored; beat count unchanged; single `en_o`.
- `reset` asserted at beat 2 of block 1 of 3 → `tvalid`=0 and IDLE next cycle; no `en_o`. A fresh `en` with `blk_cnt`=1 then completes normally.

Source files
------------

// File: rtl/aes_out_stream.sv
// aes_out_stream
// Drains the AES output FIFO once the controller reports completion and
// streams every 128-bit block as four 32-bit AXI4-Stream beats. Beat 0 is
// the most significant word. TLAST marks the final beat of the final block.
//
// Optional build macro: AES_OUT_PREFETCH_EN
//   defined   - adds a 128-bit hold buffer. The read for the next block is
//               issued while the current block streams, so consecutive
//               blocks are sent without bubbles.
//   undefined - every block boundary passes through FETCH and LOAD, which
//               leaves TVALID low for two cycles.
module aes_out_stream #(
    parameter int OUT_FIFO_ADDR_WIDTH  = 9,
    parameter int OUT_FIFO_DATA_WIDTH  = 128,
    parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            en,
    input  logic [OUT_FIFO_ADDR_WIDTH-1:0]  blk_cnt,
    output logic                            out_fifo_r_e,
    output logic [OUT_FIFO_ADDR_WIDTH-1:0]  out_fifo_addr,
    input  logic [0:OUT_FIFO_DATA_WIDTH-1]  out_fifo_data,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            busy,
    output logic                            en_o
);

    localparam int AW    = OUT_FIFO_ADDR_WIDTH;
    localparam int DW    = OUT_FIFO_DATA_WIDTH;
    localparam int TW    = C_M_AXIS_TDATA_WIDTH;
    localparam int BEATS = DW / TW;

    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [1:0]    LAST_BEAT = 2'(BEATS - 1);
`ifdef AES_OUT_PREFETCH_EN
    localparam logic [AW-1:0] TWO       = AW'(2);
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic [AW-1:0]   blk_cnt_reg;
    logic [AW-1:0]   rd_ptr_reg;     // address of the most recent FIFO read
    logic [AW-1:0]   send_idx_reg;   // block currently on the stream
    logic [AW-1:0]   addr_reg;
    logic            r_e_reg;
    logic            tvalid_reg;
    logic            busy_reg;
    logic            en_o_reg;
    logic [1:0]      beat_reg;
    logic [0:DW-1]   shift_reg;
    logic [0:DW-1]   shift_next;
    logic            handshake;
    logic            last_blk;

`ifdef AES_OUT_PREFETCH_EN
    logic [0:DW-1]   hold_reg;
    logic            fetch_d_reg;    // FIFO read data is valid this cycle
`endif

    assign handshake = tvalid_reg & m_axis_tready;
    assign last_blk  = (send_idx_reg + ONE) == blk_cnt_reg;

    // Shift the block up by one word; the word that falls off was just sent.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_shift
            if (gi < BEATS - 1) begin : g_move
                assign shift_next[gi*TW +: TW] = shift_reg[(gi+1)*TW +: TW];
            end else begin : g_fill
                assign shift_next[gi*TW +: TW] = '0;
            end
        end
    endgenerate

    assign out_fifo_r_e  = r_e_reg;
    assign out_fifo_addr = addr_reg;
    assign m_axis_tdata  = shift_reg[0:TW-1];
    assign m_axis_tvalid = tvalid_reg;
    // Derived only from registers, so it stays stable while the sink stalls.
    assign m_axis_tlast  = tvalid_reg && (beat_reg == LAST_BEAT) && last_blk;
    assign busy          = busy_reg;
    assign en_o          = en_o_reg;

`ifdef AES_OUT_PREFETCH_EN
    // Capture prefetched FIFO data one cycle after each read is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_reg    <= '0;
            fetch_d_reg <= 1'b0;
        end else begin
            fetch_d_reg <= r_e_reg;
            if (fetch_d_reg) begin
                hold_reg <= out_fifo_data;
            end
        end
    end
`endif

    // Main control FSM: start handshake, FIFO reads, beat sequencing, done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            blk_cnt_reg  <= '0;
            rd_ptr_reg   <= '0;
            send_idx_reg <= '0;
            addr_reg     <= '0;
            r_e_reg      <= 1'b0;
            tvalid_reg   <= 1'b0;
            busy_reg     <= 1'b0;
            en_o_reg     <= 1'b0;
            beat_reg     <= '0;
            shift_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    en_o_reg <= 1'b0;
                    if (en) begin
                        busy_reg    <= 1'b1;
                        blk_cnt_reg <= blk_cnt;
                        if (blk_cnt != '0) begin
                            rd_ptr_reg   <= '0;
                            send_idx_reg <= '0;
                            addr_reg     <= '0;
                            r_e_reg      <= 1'b1;
                            state_reg    <= ST_FETCH;
                        end else begin
                            state_reg    <= ST_DONE;
                        end
                    end
                end

                ST_FETCH: begin
                    r_e_reg   <= 1'b0;
                    state_reg <= ST_LOAD;
                end

                ST_LOAD: begin
                    shift_reg  <= out_fifo_data;
                    beat_reg   <= '0;
                    tvalid_reg <= 1'b1;
                    state_reg  <= ST_SEND;
`ifdef AES_OUT_PREFETCH_EN
                    // Start the next block's read as this block goes out.
                    if (!last_blk) begin
                        r_e_reg    <= 1'b1;
                        addr_reg   <= rd_ptr_reg + ONE;
                        rd_ptr_reg <= rd_ptr_reg + ONE;
                    end
`endif
                end

                ST_SEND: begin
`ifdef AES_OUT_PREFETCH_EN
                    r_e_reg <= 1'b0;
`endif
                    if (handshake) begin
                        if (beat_reg != LAST_BEAT) begin
                            beat_reg  <= beat_reg + 2'd1;
                            shift_reg <= shift_next;
                        end else if (last_blk) begin
                            // Done pulse and busy release share this edge.
                            tvalid_reg <= 1'b0;
                            en_o_reg   <= 1'b1;
                            busy_reg   <= 1'b0;
                            state_reg  <= ST_DONE;
                        end else begin
                            send_idx_reg <= send_idx_reg + ONE;
`ifdef AES_OUT_PREFETCH_EN
                            // Next block is already in the hold buffer.
                            shift_reg <= hold_reg;
                            beat_reg  <= '0;
                            if ((send_idx_reg + TWO) != blk_cnt_reg) begin
                                r_e_reg    <= 1'b1;
                                addr_reg   <= rd_ptr_reg + ONE;
                                rd_ptr_reg <= rd_ptr_reg + ONE;
                            end
`else
                            tvalid_reg <= 1'b0;
                            rd_ptr_reg <= rd_ptr_reg + ONE;
                            addr_reg   <= rd_ptr_reg + ONE;
                            r_e_reg    <= 1'b1;
                            state_reg  <= ST_FETCH;
`endif
                        end
                    end
                end

                ST_DONE: begin
                    // A streamed transfer enters DONE with en_o already high.
                    // A zero-block request arrives here with en_o low, so the
                    // pulse is raised here and cleared on the following cycle.
                    if (!en_o_reg) begin
                        en_o_reg <= 1'b1;
                        busy_reg <= 1'b0;
                    end else begin
                        en_o_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_out_stream.sv
// Testbench for aes_out_stream. A memory model with registered reads stands
// in for the output FIFO. Expected beats come from slicing each 128-bit
// block MSB word first. Timing expectations come from the documented latency
// formulas for the selected build (AES_OUT_PREFETCH_EN on or off).
module tb_aes_out_stream;

    localparam int AW = 9;

`ifdef AES_OUT_PREFETCH_EN
    localparam bit PREFETCH = 1'b1;
`else
    localparam bit PREFETCH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic [AW-1:0] blk_cnt;
    logic          out_fifo_r_e;
    logic [AW-1:0] out_fifo_addr;
    logic [0:127]  out_fifo_data;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;
    logic          en_o;

    logic [127:0]  mem [0:(1<<AW)-1];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    aes_out_stream #(.OUT_FIFO_ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .en            (en),
        .blk_cnt       (blk_cnt),
        .out_fifo_r_e  (out_fifo_r_e),
        .out_fifo_addr (out_fifo_addr),
        .out_fifo_data (out_fifo_data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .en_o          (en_o)
    );

    // FIFO read port: data appears one cycle after the read enable is sampled.
    always @(posedge clk) begin
        if (out_fifo_r_e) out_fifo_data <= mem[out_fifo_addr];
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_random(input int n);
        for (int b = 0; b < n; b++) mem[b] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Run one transfer of n blocks.
    // mode 0: tready always 1; mode 1: tready 1,0,0 repeating; mode 2: random.
    // dup_en: pulse en again (with a different count) while busy.
    task automatic run_xfer(input int n, input int mode, input bit dup_en);
        logic [32:0] exp_q[$];
        int          rd_q[$];
        logic [32:0] e;
        logic [31:0] w;
        logic        tl;
        logic [31:0] prev_data;
        logic        prev_last;
        bit          prev_stall;
        bit          done;
        int k, first_valid_k, last_hs_k, en_o_k, en_o_cnt, gaps, beats, budget;

        for (int b = 0; b < n; b++) begin
            for (int i = 0; i < 4; i++) begin
                w  = 32'(mem[b] >> (32 * (3 - i)));
                tl = (b == n - 1) && (i == 3);
                exp_q.push_back({tl, w});
            end
        end

        first_valid_k = -1; last_hs_k = -1; en_o_k = -1;
        en_o_cnt = 0; gaps = 0; beats = 0; prev_stall = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        budget = 64 * n + 32;

        @(posedge clk); #1;
        en = 1'b1;
        blk_cnt = AW'(n);
        m_axis_tready = 1'b1;

        k = 0;
        done = 1'b0;
        while (!done) begin
            @(posedge clk); #1;           // edge t+k
            en = 1'b0;
            if (dup_en && k == 3) begin
                en = 1'b1;
                blk_cnt = AW'(5);
            end
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (k % 3 == 0);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (k == 0) check_val("busy_after_en", busy, 1'b1);
            if (prev_stall) begin
                check_val("stall_tvalid", m_axis_tvalid, 1'b1);
                check_val("stall_tdata", m_axis_tdata, prev_data);
                check_val("stall_tlast", m_axis_tlast, prev_last);
            end
            prev_stall = 1'b0;
            if (m_axis_tvalid) begin
                if (first_valid_k < 0) first_valid_k = k;
                if (m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check_val("beat_overrun", beats + 1, 4 * n);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("tdata", m_axis_tdata, e[31:0]);
                        check_val("tlast", m_axis_tlast, e[32]);
                    end
                    beats++;
                    last_hs_k = k + 1;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = m_axis_tdata;
                    prev_last  = m_axis_tlast;
                end
            end else if (first_valid_k >= 0 && beats < 4 * n) begin
                gaps++;
            end
            if (out_fifo_r_e) rd_q.push_back(int'(out_fifo_addr));
            if (en_o) begin
                en_o_cnt++;
                if (en_o_k < 0) begin
                    en_o_k = k;
                    check_val("busy_at_en_o", busy, 1'b0);
                end
            end
            k++;
            if (en_o_k >= 0 && k > en_o_k + 3) done = 1'b1;
            if (k > budget) begin
                check_val("timeout_en_o", en_o_cnt, 1);
                done = 1'b1;
            end
        end

        check_val("beats", beats, 4 * n);
        check_val("reads", rd_q.size(), n);
        for (int i = 0; i < rd_q.size() && i < n; i++) check_val("rd_addr", rd_q[i], i);
        check_val("en_o_pulses", en_o_cnt, 1);
        if (n == 0) begin
            check_val("zero_en_o_time", en_o_k, 1);
            check_val("zero_no_tvalid", first_valid_k < 0, 1'b1);
        end else begin
            check_val("tvalid_rise", first_valid_k, 2);
            check_val("en_o_after_last", en_o_k, last_hs_k);
            if (mode == 0) begin
                check_val("last_hs_time", last_hs_k, PREFETCH ? (4 * n + 2) : (6 * n));
                check_val("bubbles", gaps, PREFETCH ? 0 : 2 * (n - 1));
            end
        end
        $display("xfer n=%0d mode=%0d dup=%0d beats=%0d reads=%0d en_o_at=%0d bubbles=%0d",
                 n, mode, dup_en, beats, rd_q.size(), en_o_k, gaps);
    endtask

    // Reset while block 1 beat 2 of a 3-block transfer is on the bus.
    task automatic run_reset_mid();
        int hs, k, cnt;
        bit hit;
        fill_random(3);
        @(posedge clk); #1;
        en = 1'b1;
        blk_cnt = AW'(3);
        m_axis_tready = 1'b1;
        hs = 0; k = 0; hit = 1'b0;
        while (!hit && k < 100) begin
            @(posedge clk); #1;
            en = 1'b0;
            @(negedge clk);
            if (m_axis_tvalid && hs == 6) hit = 1'b1;
            else if (m_axis_tvalid && m_axis_tready) hs++;
            k++;
        end
        check_val("reached_blk1_beat2", hit, 1'b1);
        check_val("blk1_beat2_data", m_axis_tdata, 32'(mem[1] >> 32));
        reset = 1'b1;
        m_axis_tready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_tvalid", m_axis_tvalid, 1'b0);
        check_val("rst_tlast", m_axis_tlast, 1'b0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_en_o", en_o, 1'b0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (en_o || m_axis_tvalid) cnt++;
        end
        check_val("rst_no_activity", cnt, 0);
        $display("reset mid-transfer after %0d handshakes", hs);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, mode;
        reset = 1'b1;
        en = 1'b0;
        blk_cnt = '0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_tvalid", m_axis_tvalid, 1'b0);
        check_val("reset_tlast", m_axis_tlast, 1'b0);
        check_val("reset_r_e", out_fifo_r_e, 1'b0);
        check_val("reset_addr", out_fifo_addr, 0);
        check_val("reset_busy", busy, 1'b0);
        check_val("reset_en_o", en_o, 1'b0);
        check_val("reset_tdata", m_axis_tdata, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        mem[0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        run_xfer(1, 0, 1'b0);

        for (int b = 0; b < 3; b++)
            mem[b] = {32'(4*b), 32'(4*b + 1), 32'(4*b + 2), 32'(4*b + 3)};
        run_xfer(3, 0, 1'b0);

        fill_random(2);
        run_xfer(2, 1, 1'b0);

        run_xfer(0, 0, 1'b0);

        fill_random(2);
        run_xfer(2, 0, 1'b1);

        run_reset_mid();
        fill_random(1);
        run_xfer(1, 0, 1'b0);

        for (int it = 0; it < 6; it++) begin
            n    = $urandom_range(1, 5);
            mode = $urandom_range(0, 2);
            fill_random(n);
            run_xfer(n, mode, 1'b0);
        end

        fill_random((1 << AW) - 1);
        run_xfer((1 << AW) - 1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
